// File: rtl/gate_model_test_sequencer.sv
// Stimulus sequencer for a combinational gate-library model.
// Sweeps an inclusive (possibly wrapping) input-vector range. Each vector is
// held for a fixed settle time before the model's response is captured. The
// capture is then streamed out over valid/ready and folded into a MISR
// signature.
module gate_model_test_sequencer #(
    parameter int unsigned IN_W   = 21,
    parameter int unsigned OUT_W  = 10,  // must not exceed SIG_W
    parameter int unsigned SETTLE = 2,   // settle cycles per vector, at least 1
    parameter int unsigned SIG_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [IN_W-1:0]        first_vec,
    input  logic [IN_W-1:0]        last_vec,
    output logic [IN_W-1:0]        dut_in,
    input  logic [OUT_W-1:0]       dut_out,
    output logic                   resp_valid,
    output logic [IN_W+OUT_W-1:0]  resp_data,
    input  logic                   resp_ready,
    output logic                   busy,
    output logic                   done,
    output logic [SIG_W-1:0]       signature,
    output logic [IN_W:0]          vec_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_HOLD,
        S_DONE
    } state_t;

    // The settle counter runs 0 .. SETTLE-1.
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    // Feedback taps for x^16+x^15+x^13+x^4+1: state bits 15, 14, 12 and 3.
    localparam logic [SIG_W-1:0] MISR_TAPS = SIG_W'(16'hD008);

    state_t                  state_q, state_d;
    logic [IN_W-1:0]         dut_in_q, dut_in_d;
    logic [IN_W-1:0]         last_q, last_d;
    logic                    valid_q, valid_d;
    logic [IN_W+OUT_W-1:0]   data_q, data_d;
    logic                    busy_q, busy_d;
    logic [SIG_W-1:0]        sig_q, sig_d;
    logic [IN_W:0]           count_q, count_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    xfer;
    logic                    misr_fb;

    assign xfer    = valid_q & resp_ready;
    assign misr_fb = ^(sig_q & MISR_TAPS);

    // State register and all datapath registers, asynchronously cleared.
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dut_in_q <= '0;
            last_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            sig_q    <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            sig_q    <= sig_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and datapath update for the sweep sequence.
    always_comb begin
        // NOTE: every target gets a hold-value default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d  = state_q;
        dut_in_d = dut_in_q;
        last_d   = last_q;
        valid_d  = valid_q;
        data_d   = data_q;
        busy_d   = busy_q;
        sig_d    = sig_q;
        count_d  = count_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_d   = last_vec;
                    dut_in_d = first_vec;
                    sig_d    = '0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = S_APPLY;
                end
            end

            S_APPLY: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end

            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_CAPTURE: begin
                sig_d   = {sig_q[SIG_W-2:0], misr_fb} ^ SIG_W'(dut_out);
                count_d = count_q + (IN_W + 1)'(1);
                data_d  = {dut_in_q, dut_out};
                valid_d = 1'b1;
                state_d = S_HOLD;
            end

            S_HOLD: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    if (dut_in_q == last_q) begin
                        // busy drops as DONE is entered, so it is low for the done pulse.
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        // Wraps all-ones to zero, which makes first > last a legal sweep.
                        dut_in_d = dut_in_q + IN_W'(1);
                        state_d  = S_APPLY;
                    end
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dut_in     = dut_in_q;
    assign resp_valid = valid_q;
    assign resp_data  = data_q;
    assign busy       = busy_q;
    assign done       = (state_q == S_DONE);
    assign signature  = sig_q;
    assign vec_count  = count_q;

endmodule

// File: tb/tb_gate_model_test_sequencer.sv
// Directed bench for gate_model_test_sequencer driving an echo model
// (dut_out = dut_in[9:0]).
module tb_gate_model_test_sequencer;

    localparam int IN_W  = 21;
    localparam int OUT_W = 10;
    localparam int SIG_W = 16;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [IN_W-1:0]       first_vec;
    logic [IN_W-1:0]       last_vec;
    logic [IN_W-1:0]       dut_in;
    logic [OUT_W-1:0]      dut_out;
    logic                  resp_valid;
    logic [IN_W+OUT_W-1:0] resp_data;
    logic                  resp_ready;
    logic                  busy;
    logic                  done;
    logic [SIG_W-1:0]      signature;
    logic [IN_W:0]         vec_count;

    int total = 0;
    int bad   = 0;

    gate_model_test_sequencer #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SETTLE(2),
        .SIG_W (SIG_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_vec (first_vec),
        .last_vec  (last_vec),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_ready(resp_ready),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .vec_count (vec_count)
    );

    // Echo gate model.
    assign dut_out = dut_in[OUT_W-1:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IN_W-1:0]  first;
        logic [IN_W-1:0]  last;
        int               stall_at;   // capture index to stall on, -1 for none
        int               stall_len;
        bit               mid_start;  // pulse start mid-sweep and in the done cycle
        int               exp_count;
        logic [SIG_W-1:0] exp_sig;
        int               exp_lat;    // edges from start edge to done being high
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dut_in"},     64'(dut_in),     64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_data"},  64'(resp_data),  64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_done"},       64'(done),       64'd0);
        check({tag, "_signature"},  64'(signature),  64'd0);
        check({tag, "_vec_count"},  64'(vec_count),  64'd0);
    endtask

    task automatic run_sweep(input vec_t v);
        logic [IN_W-1:0]       exp_vec;
        logic [IN_W-1:0]       prev_in;
        logic [IN_W-1:0]       snap_in;
        logic [IN_W+OUT_W-1:0] snap_data;
        logic [IN_W+OUT_W-1:0] exp_data;
        int  xfers, dones, lat, stall_left;
        bit  stalled, prev_xfer;

        exp_vec    = v.first;
        xfers      = 0;
        dones      = 0;
        lat        = -1;
        stall_left = 0;
        stalled    = 1'b0;

        @(negedge clk);
        first_vec = v.first;
        last_vec  = v.last;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        prev_in   = dut_in;
        prev_xfer = 1'b0;

        for (int k = 0; k < 2000; k++) begin
            if (dut_in !== prev_in)
                check("dut_in_changes_only_after_xfer", 64'(prev_xfer), 64'd1);
            prev_in = dut_in;

            if (done) begin
                dones++;
                lat = k;
                break;
            end

            if (v.mid_start) begin
                if (k == 7) begin
                    start     = 1'b1;
                    first_vec = 21'h0F0F0;
                    last_vec  = 21'h0F0F0;
                end else if (k == 8) begin
                    start = 1'b0;
                end
            end

            if (!stalled && resp_valid && xfers == v.stall_at) begin
                stalled    = 1'b1;
                resp_ready = 1'b0;
                stall_left = v.stall_len;
                snap_data  = resp_data;
                snap_in    = dut_in;
            end else if (stall_left > 0) begin
                check("stall_valid",  64'(resp_valid), 64'd1);
                check("stall_data",   64'(resp_data),  64'(snap_data));
                check("stall_dut_in", 64'(dut_in),     64'(snap_in));
                stall_left--;
                if (stall_left == 0) resp_ready = 1'b1;
            end

            prev_xfer = resp_valid && resp_ready;
            if (prev_xfer) begin
                exp_data = {exp_vec, exp_vec[OUT_W-1:0]};
                check("xfer_data", 64'(resp_data), 64'(exp_data));
                xfers++;
                exp_vec = exp_vec + 21'd1;
            end
            @(negedge clk);
        end

        check("done_latency", 64'(lat),       64'(v.exp_lat));
        check("xfer_count",   64'(xfers),     64'(v.exp_count));
        check("vec_count",    64'(vec_count), 64'(v.exp_count));
        check("signature",    64'(signature), 64'(v.exp_sig));

        // Optionally pulse start exactly in the done cycle; it must be ignored.
        if (v.mid_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_is_one_cycle", 64'(done), 64'd0);
        check("busy_after_done",   64'(busy), 64'd0);
        for (int k = 0; k < 10; k++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("done_pulses",     64'(dones),     64'd1);
        check("idle_after_done", 64'(busy),      64'd0);
        check("signature_held",  64'(signature), 64'(v.exp_sig));
    endtask

    initial begin
        tbl[0] = '{21'h000000, 21'h000003, -1, 0, 1'b0, 4, 16'h0003, 20};
        tbl[1] = '{21'h01ABCD, 21'h01ABCD, -1, 0, 1'b0, 1, 16'h03CD,  5};
        tbl[2] = '{21'h1FFFFE, 21'h000001, -1, 0, 1'b0, 4, 16'h1009, 20};
        tbl[3] = '{21'h000000, 21'h000003,  1, 7, 1'b0, 4, 16'h0003, 27};
        tbl[4] = '{21'h0003FE, 21'h000401, -1, 0, 1'b1, 4, 16'h1009, 20};
        tbl[5] = '{21'h000005, 21'h000005, -1, 0, 1'b0, 1, 16'h0005,  5};

        rst        = 1'b1;
        start      = 1'b0;
        resp_ready = 1'b1;
        first_vec  = '0;
        last_vec   = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Abort mid-sweep: reset during SETTLE of the second vector.
        @(negedge clk);
        first_vec = 21'h0;
        last_vec  = 21'h3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_abort_dut_in", 64'(dut_in),    64'd1);
        check("pre_abort_count",  64'(vec_count), 64'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_abort");
        begin
            int abort_dones;
            abort_dones = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (done) abort_dones++;
            end
            rst = 1'b0;
            for (int k = 0; k < 25; k++) begin
                @(negedge clk);
                if (done) abort_dones++;
            end
            check("abort_no_done", 64'(abort_dones), 64'd0);
            check("abort_idle",    64'(busy),        64'd0);
        end

        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
